// File: rtl/mmio_btn_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_btn_ctrl
//
// Debounced push-button controller on the CPU MMIO bus. Each of the N_CH raw
// pins is synchronised, debounced, and edge-detected. Press and release events
// latch into write-1-to-clear pending registers. A per-channel 16-bit
// saturating counter counts presses. A masked OR of the pending bits drives a
// registered level interrupt.
//
// Register window: 64 bytes at BASE_ADDR. The word index is mmio_addr[5:2].
//   0      STATUS      RO    stable (debounced) levels
//   1      PRESS_PEND  W1C   press events
//   2      REL_PEND    W1C   release events
//   3      IRQ_EN      RW    interrupt mask
//   8+i    CNT_i       R, any write clears; 16-bit saturating press count
//   other  reads 0, writes ignored, still complete
//
// Ports:
//   sys_clk          system clock
//   rst              asynchronous active-high reset
//   mmio_read        read request, held until mmio_done
//   mmio_write       write request, held until mmio_done (wins over read)
//   mmio_addr        byte address
//   mmio_write_data  write data
//   mmio_work        combinational address decode of the 64-byte window
//   mmio_done        one-cycle completion pulse
//   mmio_read_data   read data while mmio_done=1, otherwise 0
//   irq              registered level interrupt
//   button_pins      raw asynchronous pin levels
// -----------------------------------------------------------------------------
module mmio_btn_ctrl #(
    parameter int          N_CH       = 5,
    parameter int          DEB_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0140
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            mmio_read,
    input  logic            mmio_write,
    input  logic [31:0]     mmio_addr,
    input  logic [31:0]     mmio_write_data,
    output logic            mmio_work,
    output logic            mmio_done,
    output logic [31:0]     mmio_read_data,
    output logic            irq,
    input  logic [N_CH-1:0] button_pins
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    // Value the counter holds on the cycle where one more mismatch would make
    // it reach DEB_CYCLES-1. At that point, the level flips instead.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 2);

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] stable_q, stable_d;
    logic [N_CH-1:0] flip;
    logic [N_CH-1:0] press_ev, rel_ev;
    logic [N_CH-1:0] press_pend_q, press_pend_d;
    logic [N_CH-1:0] rel_pend_q, rel_pend_d;
    logic [N_CH-1:0] irq_en_q, irq_en_d;
    logic [N_CH-1:0][15:0] cnt_all;

    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d, rdata_c;
    logic        irq_q, irq_d;

    logic [3:0]  word;
    logic        accept, wr_acc;

    // Bits of the bus that the register map never looks at.
    logic unused_bits;
    assign unused_bits = ^{mmio_write_data[31:N_CH], mmio_addr[1:0]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign mmio_work = (mmio_addr[31:6] == BASE_ADDR[31:6]);
    assign word      = mmio_addr[5:2];
    // After a completion, one dead cycle follows, so a held request is not
    // serviced twice in a row.
    assign accept    = mmio_work & (mmio_read | mmio_write) & ~done_q;
    assign wr_acc    = accept & mmio_write;

    // ------------------------------------------------------------------
    // Per-channel debounce and press counter
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DEB_W-1:0] deb_q, deb_d;
            logic             flip_c;
            logic [15:0]      cnt_q, cnt_d;

            always_comb begin
                deb_d  = '0;
                flip_c = 1'b0;
                if (sync2_q[gi] != stable_q[gi]) begin
                    if (deb_q == DEB_LAST) begin
                        flip_c = 1'b1;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
            end

            // A clear and a press on the same edge give 1: clear first,
            // then count the press.
            always_comb begin
                cnt_d = cnt_q;
                if (wr_acc && (word == 4'(8 + gi))) begin
                    cnt_d = '0;
                end
                if (press_ev[gi] && (cnt_d != 16'hFFFF)) begin
                    cnt_d = cnt_d + 16'd1;
                end
            end

            always_ff @(posedge sys_clk or posedge rst) begin
                if (rst) begin
                    deb_q <= '0;
                    cnt_q <= '0;
                end else begin
                    deb_q <= deb_d;
                    cnt_q <= cnt_d;
                end
            end

            assign flip[gi]    = flip_c;
            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign press_ev = flip & ~stable_q;
    assign rel_ev   = flip & stable_q;
    assign stable_d = stable_q ^ flip;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        press_pend_d = press_pend_q;
        rel_pend_d   = rel_pend_q;
        irq_en_d     = irq_en_q;
        if (wr_acc && (word == 4'd1)) begin
            press_pend_d = press_pend_q & ~mmio_write_data[N_CH-1:0];
        end
        if (wr_acc && (word == 4'd2)) begin
            rel_pend_d = rel_pend_q & ~mmio_write_data[N_CH-1:0];
        end
        if (wr_acc && (word == 4'd3)) begin
            irq_en_d = mmio_write_data[N_CH-1:0];
        end
        // A new event wins over a clear on the same edge.
        press_pend_d = press_pend_d | press_ev;
        rel_pend_d   = rel_pend_d | rel_ev;
    end

    // The read mux uses pre-edge state, so a read sees the values from
    // before any update made on the completing edge.
    always_comb begin
        rdata_c = '0;
        case (word)
            4'd0:    rdata_c[N_CH-1:0] = stable_q;
            4'd1:    rdata_c[N_CH-1:0] = press_pend_q;
            4'd2:    rdata_c[N_CH-1:0] = rel_pend_q;
            4'd3:    rdata_c[N_CH-1:0] = irq_en_q;
            default: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (word == 4'(8 + k)) begin
                        rdata_c = {16'h0000, cnt_all[k]};
                    end
                end
            end
        endcase
    end

    always_comb begin
        done_d  = accept;
        rdata_d = (accept && !mmio_write) ? rdata_c : 32'h0;
        irq_d   = |((press_pend_q | rel_pend_q) & irq_en_q);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            irq_en_q     <= '0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync1_q      <= button_pins;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    assign mmio_done      = done_q;
    assign mmio_read_data = rdata_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_mmio_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_btn_ctrl
//
// Bench for mmio_btn_ctrl with N_CH=5 and DEB_CYCLES=4. A reference model is
// evaluated once per clock edge. It reads the debounced level from the pin
// history: a level changes once the twice-delayed pin samples have disagreed
// with it for DEB_CYCLES-1 consecutive edges since the last change. Every
// cycle, the bench compares done, read data, irq and work against the model.
// Directed checks against constants cover the listed scenarios.
// -----------------------------------------------------------------------------
module tb_mmio_btn_ctrl;

    localparam int          N_CH = 5;
    localparam int          DEB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF0140;
    localparam logic [25:0] BASE_TAG = BASE[31:6];

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            rd    = 1'b0;
    logic            wr    = 1'b0;
    logic [31:0]     addr  = 32'h0;
    logic [31:0]     wdata = 32'h0;
    logic [N_CH-1:0] pins  = '0;
    logic            work, done, irq;
    logic [31:0]     rdata;

    mmio_btn_ctrl #(
        .N_CH      (N_CH),
        .DEB_CYCLES(DEB),
        .BASE_ADDR (BASE)
    ) dut (
        .sys_clk        (clk),
        .rst            (rst),
        .mmio_read      (rd),
        .mmio_write     (wr),
        .mmio_addr      (addr),
        .mmio_write_data(wdata),
        .mmio_work      (work),
        .mmio_done      (done),
        .mmio_read_data (rdata),
        .irq            (irq),
        .button_pins    (pins)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model state ----------------
    logic [N_CH-1:0] ph[$];
    int              last_flip[N_CH];
    logic [N_CH-1:0] stable_m, pp_m, rp_m, en_m;
    logic [15:0]     cnt_m[N_CH];
    logic            done_m, irq_m;
    logic [31:0]     rdata_m;

    logic [31:0] r;
    int          hold = 0;
    int          pick;
    logic [3:0]  w4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph.delete();
        // The synchronizer resets to 0, which acts like two zero samples.
        ph.push_back('0);
        ph.push_back('0);
        for (int c = 0; c < N_CH; c++) begin
            last_flip[c] = 1;
            cnt_m[c]     = 16'h0;
        end
        stable_m = '0; pp_m = '0; rp_m = '0; en_m = '0;
        done_m = 1'b0; irq_m = 1'b0; rdata_m = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] wi);
        logic [31:0] v;
        v = 32'h0;
        if (wi == 4'd0) v[N_CH-1:0] = stable_m;
        else if (wi == 4'd1) v[N_CH-1:0] = pp_m;
        else if (wi == 4'd2) v[N_CH-1:0] = rp_m;
        else if (wi == 4'd3) v[N_CH-1:0] = en_m;
        else if (wi >= 4'd8 && int'(wi) < 8 + N_CH) v = {16'h0, cnt_m[int'(wi) - 8]};
        return v;
    endfunction

    task automatic model_edge();
        int              e;
        logic            held, acc, wacc;
        logic [N_CH-1:0] press, rel;
        logic [3:0]      wi;
        logic [31:0]     rv;
        ph.push_back(pins);
        e     = ph.size() - 1;
        press = '0;
        rel   = '0;
        for (int c = 0; c < N_CH; c++) begin
            held = 1'b1;
            for (int k = 0; k < DEB - 1; k++) begin
                if (e - k <= last_flip[c]) held = 1'b0;
                else if (ph[e - k - 2][c] == stable_m[c]) held = 1'b0;
            end
            if (held) begin
                last_flip[c] = e;
                if (stable_m[c]) rel[c] = 1'b1;
                else press[c] = 1'b1;
            end
        end
        wi   = addr[5:2];
        acc  = (addr[31:6] == BASE_TAG) && (rd || wr) && !done_m;
        wacc = acc && wr;
        rv   = model_read(wi);
        irq_m = |((pp_m | rp_m) & en_m);
        if (wacc && wi == 4'd1) pp_m = pp_m & ~wdata[N_CH-1:0];
        if (wacc && wi == 4'd2) rp_m = rp_m & ~wdata[N_CH-1:0];
        if (wacc && wi == 4'd3) en_m = wdata[N_CH-1:0];
        pp_m = pp_m | press;
        rp_m = rp_m | rel;
        for (int c = 0; c < N_CH; c++) begin
            if (wacc && int'(wi) == 8 + c) cnt_m[c] = 16'h0;
            if (press[c] && cnt_m[c] != 16'hFFFF) cnt_m[c] = cnt_m[c] + 16'd1;
        end
        stable_m = stable_m ^ (press | rel);
        done_m   = acc;
        rdata_m  = (acc && !wr) ? rv : 32'h0;
    endtask

    task automatic check_outputs();
        chk("done", {31'b0, done}, {31'b0, done_m});
        chk("rdata", rdata, rdata_m);
        chk("irq", {31'b0, irq}, {31'b0, irq_m});
        chk("work", {31'b0, work}, {31'b0, addr[31:6] == BASE_TAG});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_op(input logic w, input logic [5:0] off, input logic [31:0] d,
                          output logic [31:0] res);
        rd = !w; wr = w; addr = BASE | 32'(off); wdata = d;
        tick();
        res = rdata;
        rd = 1'b0; wr = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // ---- reset ----
        idle(3);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        addr = 32'h0000_0100;
        #1 chk("work_off", {31'b0, work}, 32'h0);
        addr = BASE | 32'h3C;
        #1 chk("work_on", {31'b0, work}, 32'h1);
        @(negedge clk);

        // ---- held read of STATUS: done pulses, then a dead cycle ----
        rd = 1'b1; addr = BASE;
        tick();
        chk("first_done", {31'b0, done}, 32'h1);
        chk("first_data", rdata, 32'h0);
        tick();
        chk("held_gap", {31'b0, done}, 32'h0);
        tick();
        chk("b2b_done", {31'b0, done}, 32'h1);
        rd = 1'b0;
        tick();

        // ---- ch2 press: latency ----
        bus_op(1'b1, 6'h0C, 32'h04, r);
        pins[2] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk("ch2_irq_lat", {31'b0, irq}, {31'b0, t >= 6});
        end
        bus_op(1'b0, 6'h00, 0, r); chk("ch2_status", r, 32'h04);
        bus_op(1'b0, 6'h04, 0, r); chk("ch2_press", r, 32'h04);
        bus_op(1'b0, 6'h28, 0, r); chk("ch2_cnt", r, 32'h1);
        bus_op(1'b1, 6'h04, 32'h04, r);
        bus_op(1'b1, 6'h0C, 32'h00, r);

        // ---- ch1 bouncing: filtered ----
        for (int t = 0; t < 20; t++) begin
            if (t % 2 == 0) pins[1] = ~pins[1];
            tick();
        end
        pins[1] = 1'b0;
        idle(10);
        bus_op(1'b0, 6'h00, 0, r); chk("bounce_status", r, 32'h04);
        bus_op(1'b0, 6'h04, 0, r); chk("bounce_press", r, 32'h0);
        bus_op(1'b0, 6'h24, 0, r); chk("bounce_cnt", r, 32'h0);

        // ---- ch0 press drives irq, W1C clears it ----
        bus_op(1'b1, 6'h0C, 32'h01, r);
        pins[0] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("ch0_irq_lat", {31'b0, irq}, {31'b0, t >= 6});
        end
        wr = 1'b1; addr = BASE | 32'h04; wdata = 32'h01;
        tick();
        chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
        wr = 1'b0;
        tick();
        chk("w1c_irq_fall", {31'b0, irq}, 32'h0);
        bus_op(1'b0, 6'h04, 0, r); chk("w1c_press", r, 32'h0);

        // ---- W1C colliding with ch3 press: set wins ----
        pins[3] = 1'b1;
        idle(4);
        wr = 1'b1; addr = BASE | 32'h04; wdata = 32'h08;
        tick();
        wr = 1'b0;
        tick();
        bus_op(1'b0, 6'h04, 0, r); chk("coll_press", r, 32'h08);
        bus_op(1'b0, 6'h2C, 0, r); chk("coll_cnt_a", r, 32'h1);
        pins[3] = 1'b0;
        idle(8);
        bus_op(1'b0, 6'h08, 0, r); chk("rel_pend", r, 32'h08);
        pins[3] = 1'b1;
        idle(4);
        wr = 1'b1; addr = BASE | 32'h2C; wdata = 32'h0;
        tick();
        wr = 1'b0;
        tick();
        bus_op(1'b0, 6'h2C, 0, r); chk("coll_cnt_b", r, 32'h1);

        // ---- CNT_0 saturation ----
        pins[0] = 1'b0;
        idle(8);
        force dut.g_ch[0].cnt_q = 16'hFFFE;
        #1;
        release dut.g_ch[0].cnt_q;
        cnt_m[0] = 16'hFFFE;
        pins[0] = 1'b1;
        idle(8);
        bus_op(1'b0, 6'h20, 0, r); chk("sat_a", r, 32'hFFFF);
        pins[0] = 1'b0;
        idle(8);
        pins[0] = 1'b1;
        idle(8);
        bus_op(1'b0, 6'h20, 0, r); chk("sat_b", r, 32'hFFFF);

        // ---- unmapped words ----
        bus_op(1'b0, 6'h3C, 0, r); chk("unmapped_3c", r, 32'h0);
        bus_op(1'b0, 6'h14, 0, r); chk("unmapped_14", r, 32'h0);
        bus_op(1'b0, 6'h34, 0, r); chk("cnt5_absent", r, 32'h0);
        bus_op(1'b1, 6'h0C, 32'hFFFF_FFFF, r);
        bus_op(1'b0, 6'h0C, 0, r); chk("irq_en_mask", r, 32'h1F);

        // ---- randomized traffic ----
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 15) == 0) pins[c] = ~pins[c];
            end
            if (hold == 0) begin
                rd = 1'b0; wr = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    pick = $urandom_range(0, 3);
                    rd = (pick != 1);
                    wr = (pick != 0);
                    w4 = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 9) == 0) addr = $urandom;
                    else addr = BASE | {26'h0, w4, 2'($urandom_range(0, 3))};
                    wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                    hold  = $urandom_range(1, 3);
                end
            end else begin
                hold--;
            end
            tick();
        end
        rd = 1'b0; wr = 1'b0;

        // ---- reset in the middle of a held request ----
        pins = '0;
        idle(10);
        rd = 1'b1; addr = BASE | 32'h04;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_done", {31'b0, done}, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", {31'b0, done}, 32'h1);
        chk("post_rst_data", rdata, 32'h0);
        rd = 1'b0;
        tick();
        for (int wv = 0; wv < 13; wv++) begin
            if (wv < 4 || wv >= 8) begin
                bus_op(1'b0, 6'(wv * 4), 0, r);
                chk("post_rst_reg", r, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
